// File: rtl/ctl_pkg.sv
// Shared definitions for the control sequencer: microword field layout, bus select
// codes, idle and fetch control words, and the microword-to-control decoder.
package ctl_pkg;

  localparam int unsigned UwW = 24;
  localparam int unsigned OpW = 8;

  // Microword field offsets (LSB first)
  localparam int unsigned FAddrOut  = 0;
  localparam int unsigned FAddrLoad = 3;
  localparam int unsigned FOut      = 6;
  localparam int unsigned FLoad     = 10;
  localparam int unsigned FAcInc    = 14;
  localparam int unsigned FAcDec    = 15;
  localparam int unsigned FSign     = 16;
  localparam int unsigned FEnd      = 17;
  localparam int unsigned FCond     = 18;
  localparam int unsigned FIdx      = 19;
  localparam int unsigned FHalt     = 21;

  // Address-bus device selects
  localparam logic [2:0] AselTx    = 3'd0;
  localparam logic [2:0] AselSdp   = 3'd1;
  localparam logic [2:0] AselAcalc = 3'd2;
  localparam logic [2:0] AselSp    = 3'd3;
  localparam logic [2:0] AselLr    = 3'd4;
  localparam logic [2:0] AselPc    = 3'd5;
  localparam logic [2:0] AselIdle  = 3'd7;

  // Memory-bus device selects
  localparam logic [3:0] MselIr   = 4'd8;
  localparam logic [3:0] MselMem  = 4'd9;
  localparam logic [3:0] MselTxl  = 4'd11;
  localparam logic [3:0] MselTxh  = 4'd12;
  localparam logic [3:0] MselIdle = 4'd15;

  localparam logic [OpW-1:0] IrqOpcode = 8'hFF;

  typedef struct packed {
    logic [2:0] addrout;
    logic [2:0] addrload;
    logic [3:0] out;
    logic [3:0] load;
    logic       acincn;
    logic       acdecn;
    logic       m_sign;
  } ctl_out_t;

  localparam ctl_out_t CtlIdle = '{addrout: AselIdle, addrload: AselIdle, out: MselIdle,
                                   load: MselIdle, acincn: 1'b1, acdecn: 1'b1, m_sign: 1'b0};

  // Hardwired fetch: PC onto the address bus, memory into IR, then bump PC
  localparam ctl_out_t CtlFetch = '{addrout: AselPc, addrload: AselIdle, out: MselMem,
                                    load: MselIr, acincn: 1'b0, acdecn: 1'b1, m_sign: 1'b0};

  // Only the datapath fields are passed in; sequencing bits are handled by the caller
  function automatic ctl_out_t decode_ctl(input logic [FEnd-1:0] uw);
    ctl_out_t c;
    c.addrout  = uw[FAddrOut +: 3];
    c.addrload = uw[FAddrLoad +: 3];
    c.out      = uw[FOut +: 4];
    c.load     = uw[FLoad +: 4];
    c.acincn   = ~uw[FAcInc];
    c.acdecn   = ~uw[FAcDec];
    c.m_sign   = uw[FSign];
    return c;
  endfunction

endpackage

// File: rtl/step_counter.sv
// Micro-step counter: synchronous clear, load-to-one (interrupt entry), increment,
// hold otherwise; wrap flags the last step.
module step_counter #(
  parameter int unsigned STEP_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              start,
  input  logic              inc,
  output logic [STEP_W-1:0] count,
  output logic              wrap
);

  logic [STEP_W-1:0] count_q, count_d;

  // Next count: clear beats start beats increment
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (start) begin
      count_d = STEP_W'(1);
    end else if (inc) begin
      count_d = count_q + STEP_W'(1);
    end
  end

  // Count register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign wrap  = &count_q;

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer: forms {opcode, step} ROM addresses, unpacks microwords into
// bus/counter controls, handles end, conditional exit, wrap and sticky halt.
// Optional interrupt entry is compiled in with CTL_IRQ_EN.
module control_sequencer
  import ctl_pkg::*;
#(
  parameter int unsigned STEP_W = 4,
  parameter int unsigned UW_W   = UwW
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [OpW-1:0]          opcode,
  input  logic [3:0]              flags,
  output logic [OpW+STEP_W-1:0]   uc_addr,
  input  logic [UW_W-1:0]         uc_data,
  output logic [2:0]              addroutctl,
  output logic [2:0]              addrloadctl,
  output logic [3:0]              outctl,
  output logic [3:0]              loadctl,
  output logic                    acincn,
  output logic                    acdecn,
  output logic                    m_sign,
  output logic [STEP_W-1:0]       step,
  output logic                    halted
`ifdef CTL_IRQ_EN
  ,
  input  logic                    irq,
  output logic                    irq_ack
`endif
);

  typedef enum logic {StRun, StHalted} state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] step_q;
  logic              wrap;
  logic              to_zero, clr, start, inc;
  logic [OpW-1:0]    opcode_eff;
  ctl_out_t          ctl;

  // Reserved microword bits carry no meaning
  logic unused_uw;
  assign unused_uw = ^uc_data[UW_W-1:FHalt+1];

  step_counter #(
    .STEP_W (STEP_W)
  ) u_step_counter (
    .clk   (clk),
    .rst   (rst),
    .clear (clr),
    .start (start),
    .inc   (inc),
    .count (step_q),
    .wrap  (wrap)
  );

  // Decode the current step into controls and pick the next-step action
  always_comb begin
    state_d = state_q;
    ctl     = CtlIdle;
    to_zero = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      StRun: begin
        if (step_q == '0) begin
          ctl = CtlFetch;
          inc = 1'b1;
        end else if (uc_data[FCond] && !flags[uc_data[FIdx +: 2]]) begin
          // Failed condition: word suppressed, instruction ends here
          to_zero = 1'b1;
        end else begin
          ctl = decode_ctl(uc_data[FEnd-1:0]);
          if (uc_data[FHalt]) begin
            state_d = StHalted;
          end else if (uc_data[FEnd] || wrap) begin
            to_zero = 1'b1;
          end else begin
            inc = 1'b1;
          end
        end
      end
      StHalted: ;
      default: ;
    endcase
  end

`ifdef CTL_IRQ_EN
  logic irq_active_q, irq_active_d;
  logic irq_ack_q, irq_ack_d;

  // At an instruction boundary, divert into the interrupt routine instead of fetching
  always_comb begin
    clr          = 1'b0;
    start        = 1'b0;
    irq_ack_d    = 1'b0;
    irq_active_d = irq_active_q;
    if (to_zero) begin
      if (irq && !irq_active_q) begin
        start        = 1'b1;
        irq_active_d = 1'b1;
        irq_ack_d    = 1'b1;
      end else begin
        clr          = 1'b1;
        irq_active_d = 1'b0;
      end
    end
  end

  // Interrupt bookkeeping registers
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_active_q <= 1'b0;
      irq_ack_q    <= 1'b0;
    end else begin
      irq_active_q <= irq_active_d;
      irq_ack_q    <= irq_ack_d;
    end
  end

  assign irq_ack    = irq_ack_q;
  assign opcode_eff = irq_active_q ? IrqOpcode : opcode;
`else
  // Without interrupts every boundary returns straight to fetch
  always_comb begin
    clr   = to_zero;
    start = 1'b0;
  end

  assign opcode_eff = opcode;
`endif

  // Run/halt state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
    end else begin
      state_q <= state_d;
    end
  end

  assign uc_addr     = {opcode_eff, step_q};
  assign addroutctl  = ctl.addrout;
  assign addrloadctl = ctl.addrload;
  assign outctl      = ctl.out;
  assign loadctl     = ctl.load;
  assign acincn      = ctl.acincn;
  assign acdecn      = ctl.acdecn;
  assign m_sign      = ctl.m_sign;
  assign step        = step_q;
  assign halted      = (state_q == StHalted);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed scenarios followed by random opcodes, flags,
// ROM contents and resets, all checked against a cycle-level behavioural model.
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic [7:0]  opcode;
  logic [3:0]  flags;
  logic [11:0] uc_addr;
  logic [23:0] uc_data;
  logic [2:0]  addroutctl, addrloadctl;
  logic [3:0]  outctl, loadctl;
  logic        acincn, acdecn, m_sign;
  logic [3:0]  step;
  logic        halted;
`ifdef CTL_IRQ_EN
  logic        irq;
  logic        irq_ack;
`endif

  logic [23:0] rom [0:4095];
  assign uc_data = rom[uc_addr];

  control_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .flags       (flags),
    .uc_addr     (uc_addr),
    .uc_data     (uc_data),
    .addroutctl  (addroutctl),
    .addrloadctl (addrloadctl),
    .outctl      (outctl),
    .loadctl     (loadctl),
    .acincn      (acincn),
    .acdecn      (acdecn),
    .m_sign      (m_sign),
    .step        (step),
    .halted      (halted)
`ifdef CTL_IRQ_EN
    ,
    .irq         (irq),
    .irq_ack     (irq_ack)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int m_step;
  int m_halt;
  int m_irqa;
  int m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] mkw(int ao, int al, int o, int l, int inc, int dec, int sg,
                                      int e, int c, int idx, int h);
    int v;
    v = ao + (al << 3) + (o << 6) + (l << 10) + (inc << 14) + (dec << 15) + (sg << 16)
        + (e << 17) + (c << 18) + (idx << 19) + (h << 21);
    return v[23:0];
  endfunction

  function automatic logic [23:0] plain(int ao, int l, int e);
    return mkw(ao, 7, 15, l, 0, 0, 0, e, 0, 0, 0);
  endfunction

  task automatic model_reset();
    m_step = 0;
    m_halt = 0;
    m_irqa = 0;
    m_ack  = 0;
  endtask

  // Check every output against the model for this cycle, then advance one clock
  task automatic tick();
    int eff, w, e_ao, e_al, e_o, e_l, e_inc, e_dec, e_sg;
    int n_step, n_halt, n_irqa, n_ack, boundary;
    #1;
    eff      = (m_irqa != 0) ? 255 : int'(opcode);
    w        = int'(rom[eff * 16 + m_step]);
    e_ao = 7; e_al = 7; e_o = 15; e_l = 15; e_inc = 1; e_dec = 1; e_sg = 0;
    n_step   = m_step;
    n_halt   = m_halt;
    n_irqa   = m_irqa;
    n_ack    = 0;
    boundary = 0;
    if (m_halt != 0) begin
      // frozen, idle
    end else if (m_step == 0) begin
      e_ao = 5; e_o = 9; e_l = 8; e_inc = 0;
      n_step = 1;
    end else if (((w >> 18) & 1) == 1 && ((int'(flags) >> ((w >> 19) & 3)) & 1) == 0) begin
      boundary = 1;
    end else begin
      e_ao  = w & 7;
      e_al  = (w >> 3) & 7;
      e_o   = (w >> 6) & 15;
      e_l   = (w >> 10) & 15;
      e_inc = 1 - ((w >> 14) & 1);
      e_dec = 1 - ((w >> 15) & 1);
      e_sg  = (w >> 16) & 1;
      if (((w >> 21) & 1) == 1) n_halt = 1;
      else if (((w >> 17) & 1) == 1 || m_step == 15) boundary = 1;
      else n_step = m_step + 1;
    end
    if (boundary != 0) begin
      n_step = 0;
      n_irqa = 0;
`ifdef CTL_IRQ_EN
      if (irq === 1'b1 && m_irqa == 0) begin
        n_step = 1;
        n_irqa = 1;
        n_ack  = 1;
      end
`endif
    end
    chk("uc_addr", uc_addr, eff * 16 + m_step);
    chk("step", step, m_step);
    chk("halted", halted, m_halt);
    chk("addroutctl", addroutctl, e_ao);
    chk("addrloadctl", addrloadctl, e_al);
    chk("outctl", outctl, e_o);
    chk("loadctl", loadctl, e_l);
    chk("acincn", acincn, e_inc);
    chk("acdecn", acdecn, e_dec);
    chk("m_sign", m_sign, e_sg);
`ifdef CTL_IRQ_EN
    chk("irq_ack", irq_ack, m_ack);
`endif
    if (rst === 1'b1) begin
      model_reset();
    end else begin
      m_step = n_step;
      m_halt = n_halt;
      m_irqa = n_irqa;
      m_ack  = n_ack;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    rst    = 1'b1;
    opcode = 8'h00;
    flags  = 4'h0;
`ifdef CTL_IRQ_EN
    irq    = 1'b0;
`endif
    for (int i = 0; i < 4096; i++) rom[i] = plain(7, 15, 1);

    rom[12'h101] = plain(7, 12, 1);
    rom[12'h201] = mkw(7, 7, 15, 11, 0, 0, 0, 0, 1, 1, 0);
    rom[12'h202] = plain(7, 12, 1);
    for (int i = 0; i < 16; i++) rom[12'h300 + i] = mkw(i % 8, 7, i, 15, 0, 0, 0, 0, 0, 0, 0);
    rom[12'h401] = plain(3, 15, 0);
    rom[12'h402] = mkw(4, 7, 15, 15, 0, 0, 0, 1, 0, 0, 1);
    for (int i = 1; i < 6; i++) rom[12'h500 + i] = plain(i % 8, 15, 0);
    rom[12'h506] = plain(7, 15, 1);
    rom[12'h601] = plain(7, 12, 1);
    rom[12'hFF1] = plain(7, 11, 0);
    rom[12'hFF2] = plain(7, 15, 1);

    // Fetch, one-word instruction, back to fetch
    do_reset();
    opcode = 8'h10;
    #1;
    chk("rst_step", step, 0);
    chk("fetch_addrout", addroutctl, 5);
    chk("fetch_out", outctl, 9);
    chk("fetch_load", loadctl, 8);
    chk("fetch_acincn", acincn, 0);
    tick();
    #1;
    chk("end_word_load", loadctl, 12);
    tick();
    #1;
    chk("after_end_step", step, 0);

    // Conditional word, Z clear then Z set
    opcode = 8'h20;
    flags  = 4'b0000;
    tick();
    #1;
    chk("condfail_load_idle", loadctl, 15);
    tick();
    #1;
    chk("condfail_step0", step, 0);
    flags = 4'b0010;
    tick();
    #1;
    chk("condpass_load", loadctl, 11);
    tick();
    #1;
    chk("condpass_step2", step, 2);
    tick();

    // No end bit anywhere: wrap guard after step 15
    opcode = 8'h30;
    tick();
    for (int i = 1; i < 16; i++) begin
      #1;
      chk("wrap_step", step, i);
      tick();
    end
    #1;
    chk("wrap_to_zero", step, 0);

    // Halt (with end) at step 2
    opcode = 8'h40;
    tick();
    tick();
    #1;
    chk("halt_word_addrout", addroutctl, 4);
    chk("halt_word_not_halted", halted, 0);
    tick();
    for (int i = 0; i < 20; i++) begin
      #1;
      chk("halted_flag", halted, 1);
      chk("halted_addrout_idle", addroutctl, 7);
      chk("halted_step_frozen", step, 2);
      tick();
    end
    do_reset();
    #1;
    chk("unhalt_step", step, 0);
    chk("unhalt_halted", halted, 0);

    // Reset in the middle of a six-step instruction
    opcode = 8'h50;
    tick();
    tick();
    tick();
    #1;
    chk("mid_step3", step, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_step", step, 0);
    chk("mid_rst_fetch", addroutctl, 5);
    chk("mid_rst_acincn", acincn, 0);
    tick();

`ifdef CTL_IRQ_EN
    // Interrupt taken at the end word, routine at 0xFF, then normal fetch
    do_reset();
    opcode = 8'h60;
    tick();
    irq = 1'b1;
    tick();
    #1;
    chk("irq_uc_addr", uc_addr, 12'hFF1);
    chk("irq_ack_pulse", irq_ack, 1);
    chk("irq_no_pc_inc", acincn, 1);
    chk("irq_step", step, 1);
    tick();
    #1;
    chk("irq_ack_cleared", irq_ack, 0);
    tick();
    irq = 1'b0;
    #1;
    chk("isr_return_step", step, 0);
    chk("isr_return_fetch", addroutctl, 5);
    tick();
`endif

    // Random ROM, opcodes, flags and occasional reset
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 24'($urandom);
      if ($urandom_range(63) != 0) rom[i][21] = 1'b0;
    end
    do_reset();
    for (int c = 0; c < 600; c++) begin
      opcode = 8'($urandom);
      flags  = 4'($urandom);
`ifdef CTL_IRQ_EN
      irq    = ($urandom_range(5) == 0);
`endif
      rst    = ($urandom_range(39) == 0);
      tick();
      rst    = 1'b0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
